// File: rtl/riscv_mem_arbiter.sv
// Single-port memory arbiter sharing one synchronous-read memory between instruction fetch
// and data access. Data wins by default; a starvation counter bounds how long fetch can wait.
module riscv_mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,

    input  logic              if_req_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_gnt_out,
    output logic              if_rvalid_out,
    output logic [DATA_W-1:0] if_rdata_out,
    output logic              if_stall_out,

    input  logic              dm_req_in,
    input  logic              dm_we_in,
    input  logic [3:0]        dm_be_in,
    input  logic [ADDR_W-1:0] dm_addr_in,
    input  logic [DATA_W-1:0] dm_wdata_in,
    output logic              dm_gnt_out,
    output logic              dm_rvalid_out,
    output logic [DATA_W-1:0] dm_rdata_out,
    output logic              dm_stall_out,

    output logic              mem_en_out,
    output logic [3:0]        mem_we_out,
    output logic [ADDR_W-3:0] mem_addr_out,
    output logic [DATA_W-1:0] mem_wdata_out,
    input  logic [DATA_W-1:0] mem_rdata_in
);

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_IF   = 2'd1;
    localparam logic [1:0] RESP_DM   = 2'd2;

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [1:0] resp_own_q, resp_own_d;
    logic       fetch_pri;
    logic       if_gnt;
    logic       dm_gnt;

    always_comb begin
        fetch_pri = (starve_cnt_q >= StarveMax);
        dm_gnt    = dm_req_in & ~(if_req_in & fetch_pri);
        if_gnt    = if_req_in & ~dm_gnt;
    end

    assign if_gnt_out   = if_gnt;
    assign dm_gnt_out   = dm_gnt;
    assign if_stall_out = if_req_in & ~if_gnt;
    assign dm_stall_out = dm_req_in & ~dm_gnt;

    always_comb begin
        mem_en_out    = if_gnt | dm_gnt;
        mem_we_out    = 4'b0000;
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        if (dm_gnt) begin
            mem_addr_out  = dm_addr_in[ADDR_W-1:2];
            mem_wdata_out = dm_wdata_in;
            if (dm_we_in) begin
                mem_we_out = dm_be_in;
            end
        end else if (if_gnt) begin
            mem_addr_out = if_addr_in[ADDR_W-1:2];
        end
    end

    always_comb begin
        resp_own_d = RESP_NONE;
        if (if_gnt) begin
            resp_own_d = RESP_IF;
        end else if (dm_gnt && !dm_we_in) begin
            resp_own_d = RESP_DM;
        end

        // Count only consecutive denied fetch cycles; a withdrawn request starts over.
        starve_cnt_d = 4'd0;
        if (if_req_in && !if_gnt) begin
            starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_cnt_q <= 4'd0;
            resp_own_q   <= RESP_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            resp_own_q   <= resp_own_d;
        end
    end

    assign if_rvalid_out = (resp_own_q == RESP_IF);
    assign dm_rvalid_out = (resp_own_q == RESP_DM);
    assign if_rdata_out  = if_rvalid_out ? mem_rdata_in : '0;
    assign dm_rdata_out  = dm_rvalid_out ? mem_rdata_in : '0;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_in[1:0], dm_addr_in[1:0]};

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: directed vector table from the test plan, then random traffic
// compared every cycle against a cycle-level reference model and a behavioural memory.
module tb_riscv_mem_arbiter;

    localparam int unsigned STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        if_gnt, if_rvalid, if_stall, dm_gnt, dm_rvalid, dm_stall, mem_en;
    logic [31:0] if_rdata, dm_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_we;
    logic [29:0] mem_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE_MAX)) dut (
        .clk_in(clk), .rst_in(rst),
        .if_req_in(if_req), .if_addr_in(if_addr), .if_gnt_out(if_gnt),
        .if_rvalid_out(if_rvalid), .if_rdata_out(if_rdata), .if_stall_out(if_stall),
        .dm_req_in(dm_req), .dm_we_in(dm_we), .dm_be_in(dm_be), .dm_addr_in(dm_addr),
        .dm_wdata_in(dm_wdata), .dm_gnt_out(dm_gnt), .dm_rvalid_out(dm_rvalid),
        .dm_rdata_out(dm_rdata), .dm_stall_out(dm_stall),
        .mem_en_out(mem_en), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
        .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
    );

    // Behavioural synchronous-read memory attached to the arbiter's memory port.
    logic [31:0] tb_mem [64];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'b0000) begin
                mem_rdata <= tb_mem[mem_addr[5:0]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we[b]) tb_mem[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Reference model state: memory image, fetch wait count, pending read response.
    logic [31:0] ref_mem [64];
    int          waited;
    int          pend_port;  // 0 none, 1 fetch, 2 data
    logic [31:0] pend_data;
    logic        e_ig, e_dg;

    typedef struct {
        logic        rst, ir, dr, dwe;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dbe;
        logic        eig, edg, eirv, edrv;
        logic [29:0] ema;
        logic [3:0]  emwe;
        logic [31:0] emwd, erd;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;

    task automatic add(input logic r, ir, input logic [31:0] ia, input logic dr, dwe,
                       input logic [3:0] dbe, input logic [31:0] da, dwd,
                       input logic eig, edg, input logic [29:0] ema, input logic [3:0] emwe,
                       input logic [31:0] emwd, input logic eirv, edrv,
                       input logic [31:0] erd);
        vecs[nvec] = '{rst: r, ir: ir, dr: dr, dwe: dwe, ia: ia, da: da, dwd: dwd, dbe: dbe,
                       eig: eig, edg: edg, eirv: eirv, edrv: edrv, ema: ema, emwe: emwe,
                       emwd: emwd, erd: erd};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare all outputs against the model; called mid-cycle with inputs settled.
    task automatic model_check();
        logic [29:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        // Fetch overtakes data only after it has been refused STARVE_MAX cycles in a row.
        e_dg = dm_req && !(if_req && waited >= STARVE_MAX);
        e_ig = if_req && !e_dg;
        a  = e_dg ? dm_addr[31:2] : (e_ig ? if_addr[31:2] : 30'h0);
        we = (e_dg && dm_we) ? dm_be : 4'h0;
        wd = e_dg ? dm_wdata : 32'h0;
        chk("if_gnt", 64'(if_gnt), 64'(e_ig));
        chk("dm_gnt", 64'(dm_gnt), 64'(e_dg));
        chk("if_stall", 64'(if_stall), 64'(if_req && !e_ig));
        chk("dm_stall", 64'(dm_stall), 64'(dm_req && !e_dg));
        chk("mem_en", 64'(mem_en), 64'(e_ig || e_dg));
        chk("mem_addr", 64'(mem_addr), 64'(a));
        chk("mem_we", 64'(mem_we), 64'(we));
        chk("mem_wdata", 64'(mem_wdata), 64'(wd));
        chk("if_rvalid", 64'(if_rvalid), 64'(pend_port == 1));
        chk("dm_rvalid", 64'(dm_rvalid), 64'(pend_port == 2));
        chk("if_rdata", 64'(if_rdata), (pend_port == 1) ? 64'(pend_data) : 64'h0);
        chk("dm_rdata", 64'(dm_rdata), (pend_port == 2) ? 64'(pend_data) : 64'h0);
    endtask

    // Advance to the next cycle and fold this cycle's effects into the model.
    task automatic model_advance();
        int          idx;
        logic [31:0] rd;
        idx = e_dg ? int'(dm_addr[7:2]) : int'(if_addr[7:2]);
        rd  = ref_mem[idx];
        if (e_dg && dm_we) begin
            for (int b = 0; b < 4; b++) begin
                if (dm_be[b]) ref_mem[idx][8*b +: 8] = dm_wdata[8*b +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            waited    = 0;
            pend_port = 0;
        end else begin
            waited    = (if_req && !e_ig) ? ((waited < 15) ? waited + 1 : 15) : 0;
            pend_port = e_ig ? 1 : ((e_dg && !dm_we) ? 2 : 0);
            pend_data = rd;
        end
    endtask

    localparam logic [31:0] W0  = 32'hCAFE_0000;
    localparam logic [31:0] W1  = 32'hCAFE_0001;

    initial begin
        for (int i = 0; i < 64; i++) begin
            tb_mem[i]  = 32'hCAFE_0000 + 32'(i);
            ref_mem[i] = 32'hCAFE_0000 + 32'(i);
        end
        waited = 0; pend_port = 0; pend_data = 32'h0;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0;
        if_addr = 32'h0; dm_addr = 32'h0; dm_wdata = 32'h0;

        // Reset and idle.
        add(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        // Back-to-back fetches.
        add(0, 1, 32'h0, 0, 0, 0, 0, 0,  1, 0, 30'h0, 0, 0, 0, 0, 0);
        add(0, 1, 32'h4, 0, 0, 0, 0, 0,  1, 0, 30'h1, 0, 0, 1, 0, W0);
        add(0, 1, 32'h8, 0, 0, 0, 0, 0,  1, 0, 30'h2, 0, 0, 1, 0, W1);
        // Load/fetch collision.
        add(0, 1, 32'h40, 1, 0, 0, 32'h2C, 0,  0, 1, 30'hB, 0, 0, 1, 0, 32'hCAFE_0002);
        add(0, 1, 32'h40, 0, 0, 0, 0, 0,  1, 0, 30'h10, 0, 0, 0, 1, 32'hCAFE_000B);
        // Store, then read it back.
        add(0, 0, 0, 1, 1, 4'b0011, 32'h8, 32'hF000_1234,
            0, 1, 30'h2, 4'b0011, 32'hF000_1234, 1, 0, 32'hCAFE_0010);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 32'h8, 0,  0, 1, 30'h2, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1, 32'hCAFE_1234);
        // Starvation: data 4 cycles, fetch on the 5th, twice.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0, 0, 1, 30'h1, 0, 0,
                    (r == 1 && k == 0), (k != 0 || r == 1) && !(r == 1 && k == 0),
                    (r == 1 && k == 0) ? W0 : ((k == 0) ? 32'h0 : W1));
            end
            add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0,  1, 0, 30'h0, 0, 0, 0, 1, W1);
        end
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, W0);
        // Reset while a load is granted: its response is dropped.
        add(1, 1, 32'h0, 1, 0, 0, 32'hC, 0,  0, 1, 30'h3, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
        // Withdrawal after 2 denials restarts the count.
        add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0,  0, 1, 30'h1, 0, 0, 0, 0, 0);
        add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0,  0, 1, 30'h1, 0, 0, 0, 1, W1);
        add(0, 0, 32'h0, 1, 0, 0, 32'h4, 0,  0, 1, 30'h1, 0, 0, 0, 1, W1);
        for (int k = 0; k < 4; k++) begin
            add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0,  0, 1, 30'h1, 0, 0, 0, 1, W1);
        end
        add(0, 1, 32'h0, 1, 0, 0, 32'h4, 0,  1, 0, 30'h0, 0, 0, 0, 1, W1);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1, 0, W0);

        @(posedge clk);
        #1;
        for (int i = 0; i < nvec; i++) begin
            rst = vecs[i].rst; if_req = vecs[i].ir; if_addr = vecs[i].ia;
            dm_req = vecs[i].dr; dm_we = vecs[i].dwe; dm_be = vecs[i].dbe;
            dm_addr = vecs[i].da; dm_wdata = vecs[i].dwd;
            #3;
            model_check();
            chk($sformatf("vec%0d.if_gnt", i), 64'(if_gnt), 64'(vecs[i].eig));
            chk($sformatf("vec%0d.dm_gnt", i), 64'(dm_gnt), 64'(vecs[i].edg));
            chk($sformatf("vec%0d.mem_addr", i), 64'(mem_addr), 64'(vecs[i].ema));
            chk($sformatf("vec%0d.mem_we", i), 64'(mem_we), 64'(vecs[i].emwe));
            chk($sformatf("vec%0d.mem_wdata", i), 64'(mem_wdata), 64'(vecs[i].emwd));
            chk($sformatf("vec%0d.if_rvalid", i), 64'(if_rvalid), 64'(vecs[i].eirv));
            chk($sformatf("vec%0d.dm_rvalid", i), 64'(dm_rvalid), 64'(vecs[i].edrv));
            chk($sformatf("vec%0d.rdata", i), 64'(if_rdata | dm_rdata), 64'(vecs[i].erd));
            model_advance();
        end

        // Random traffic; reset only with requests low.
        for (int c = 0; c < 500; c++) begin
            rst = ($urandom_range(0, 60) == 0);
            if_req   = !rst && ($urandom_range(0, 3) != 0);
            dm_req   = !rst && ($urandom_range(0, 1) != 0);
            if_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            dm_addr  = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
            dm_we    = ($urandom_range(0, 2) == 0);
            dm_be    = 4'($urandom);
            dm_wdata = $urandom;
            #3;
            model_check();
            model_advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
